// File: rtl/food_placer_ctrl_pkg.sv
// Grid constants, state encodings and shared cell type for snake food placement.
// Grid size and retry default may be overridden by pre-defining the macros.
`ifndef GRID_WIDTH
`define GRID_WIDTH 10
`endif
`ifndef GRID_HEIGHT
`define GRID_HEIGHT 6
`endif
`ifndef FOOD_MAX_TRIES
`define FOOD_MAX_TRIES 8
`endif
`ifndef FP_IDLE
`define FP_IDLE     3'd0
`define FP_QUERY    3'd1
`define FP_RESAMPLE 3'd2
`define FP_SCAN     3'd3
`define FP_COMMIT   3'd4
`define FP_FULL     3'd5
`endif

package food_placer_ctrl_pkg;

    localparam int unsigned GRID_W = `GRID_WIDTH;
    localparam int unsigned GRID_H = `GRID_HEIGHT;
    localparam int unsigned CELLS  = GRID_W * GRID_H;
    localparam int unsigned XW     = $clog2(GRID_W);
    localparam int unsigned YW     = $clog2(GRID_H);
    localparam int unsigned SW     = $clog2(CELLS + 1);
    localparam int unsigned TW     = 8;

    typedef enum logic [2:0] {
        S_IDLE     = `FP_IDLE,
        S_QUERY    = `FP_QUERY,
        S_RESAMPLE = `FP_RESAMPLE,
        S_SCAN     = `FP_SCAN,
        S_COMMIT   = `FP_COMMIT,
        S_FULL     = `FP_FULL
    } fp_state_e;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cell_t;

    // True when the cell lies on the playable grid.
    function automatic logic in_grid(input cell_t c);
        return (c.x <= XW'(GRID_W - 1)) && (c.y <= YW'(GRID_H - 1));
    endfunction

endpackage

// File: rtl/food_raster_step.sv
// Next cell in raster order with x/y wrap; off-grid cells restart at (0,0).
module food_raster_step
    import food_placer_ctrl_pkg::*;
(
    input  cell_t cur,
    output cell_t next_c
);

    always_comb begin
        next_c = '0;
        if (in_grid(cur)) begin
            if (cur.x == XW'(GRID_W - 1)) begin
                next_c.x = '0;
                next_c.y = (cur.y == YW'(GRID_H - 1)) ? '0 : cur.y + YW'(1);
            end else begin
                next_c.x = cur.x + XW'(1);
                next_c.y = cur.y;
            end
        end
    end

endmodule

// File: rtl/food_placer_ctrl.sv
// Food placement sequencer: random candidate retries, then raster-scan fallback.
// Optional FOOD_PLACE_STATS_EN adds LastTries/ScanCycles placement statistics.
module food_placer_ctrl
    import food_placer_ctrl_pkg::*;
#(
    parameter int unsigned MAX_TRIES = `FOOD_MAX_TRIES
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          PlaceReq,
    input  logic          ClearFood,
    input  logic [XW-1:0] CandX,
    input  logic [YW-1:0] CandY,
    output logic          OccReq,
    output logic [XW-1:0] OccX,
    output logic [YW-1:0] OccY,
    input  logic          OccAck,
    input  logic          OccHit,
    output logic [XW-1:0] FoodX,
    output logic [YW-1:0] FoodY,
    output logic          FoodValid,
    output logic          PlaceDone,
    output logic          GridFull,
    output logic          Busy
`ifdef FOOD_PLACE_STATS_EN
    ,
    output logic [7:0]    LastTries,
    output logic [15:0]   ScanCycles
`endif
);

    fp_state_e       state, state_d;
    cell_t           query, query_d;
    cell_t           food, food_d;
    cell_t           step_c;
    cell_t           cand_c;
    logic [TW-1:0]   tries, tries_d;
    logic [SW-1:0]   scan, scan_d;
    logic            food_valid_d, place_done_d, grid_full_d, occ_req_d, busy_d;
    logic            hit_c, free_c;

    food_raster_step u_step (
        .cur    (query),
        .next_c (step_c)
    );

    assign cand_c = '{x: CandX, y: CandY};
    assign OccX   = query.x;
    assign OccY   = query.y;
    assign FoodX  = food.x;
    assign FoodY  = food.y;

    // Off-grid cells count as occupied without waiting on the body store.
    assign hit_c  = !in_grid(query) || (OccAck && OccHit);
    assign free_c = in_grid(query) && OccAck && !OccHit;

    always_comb begin
        state_d      = state;
        query_d      = query;
        tries_d      = tries;
        scan_d       = scan;
        food_d       = food;
        food_valid_d = FoodValid;
        grid_full_d  = GridFull;
        place_done_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (PlaceReq) begin
                    query_d     = cand_c;
                    tries_d     = TW'(1);
                    scan_d      = '0;
                    grid_full_d = 1'b0;
                    if (ClearFood) food_valid_d = 1'b0;
                    state_d     = S_QUERY;
                end else if (ClearFood) begin
                    food_valid_d = 1'b0;
                end
            end
            S_QUERY: begin
                if (hit_c) begin
                    if (tries < TW'(MAX_TRIES)) begin
                        state_d = S_RESAMPLE;
                    end else begin
                        scan_d  = SW'(1);
                        query_d = step_c;
                        state_d = S_SCAN;
                    end
                end else if (free_c) begin
                    state_d = S_COMMIT;
                end
            end
            S_RESAMPLE: begin
                query_d = cand_c;
                tries_d = tries + TW'(1);
                state_d = S_QUERY;
            end
            S_SCAN: begin
                if (free_c) begin
                    state_d = S_COMMIT;
                end else if (hit_c) begin
                    if (scan == SW'(CELLS)) begin
                        state_d = S_FULL;
                    end else begin
                        scan_d  = scan + SW'(1);
                        query_d = step_c;
                    end
                end
            end
            S_COMMIT: begin
                food_d       = query;
                food_valid_d = 1'b1;
                place_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_FULL: begin
                grid_full_d  = 1'b1;
                food_valid_d = 1'b0;
                place_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        occ_req_d = (state_d == S_QUERY) || ((state_d == S_SCAN) && in_grid(query_d));
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            query     <= '0;
            food      <= '0;
            tries     <= '0;
            scan      <= '0;
            FoodValid <= 1'b0;
            PlaceDone <= 1'b0;
            GridFull  <= 1'b0;
            OccReq    <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_d;
            query     <= query_d;
            food      <= food_d;
            tries     <= tries_d;
            scan      <= scan_d;
            FoodValid <= food_valid_d;
            PlaceDone <= place_done_d;
            GridFull  <= grid_full_d;
            OccReq    <= occ_req_d;
            Busy      <= busy_d;
        end
    end

`ifdef FOOD_PLACE_STATS_EN
    logic [15:0] busy_cnt;

    // Busy-cycle count includes the final COMMIT/FULL cycle; scan path reports 0xFF tries.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_cnt   <= '0;
            LastTries  <= '0;
            ScanCycles <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (PlaceReq) busy_cnt <= '0;
            end else if (busy_cnt != 16'hFFFF) begin
                busy_cnt <= busy_cnt + 16'd1;
            end
            if ((state == S_COMMIT) || (state == S_FULL)) begin
                LastTries  <= (scan != '0) ? 8'hFF : tries;
                ScanCycles <= (busy_cnt == 16'hFFFF) ? busy_cnt : busy_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
